// File: rtl/nibble_serial_sub32.sv
// Serial subtractor: computes a - b - bin one SLICE-bit slice per clock, LSB slice first.
// Results (diff, bout, of) appear together at the end of the run and hold until the next completion.
module nibble_serial_sub32 #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             of,
  output logic [1:0]       o_dbg_state
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic             r_borrow;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_of;

  logic             w_last;
  logic             w_accept;
  logic [SLICE:0]   w_sub;
  logic [WIDTH-1:0] w_part_next;

  // Handshake: start is a level request, taken on any rising edge where the FSM is in IDLE or DONE;
  // while busy it is ignored. done is a single-cycle result-valid strobe with no back-pressure.
  assign w_last      = (r_k == KW'(N - 1));
  assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Operands are shifted right each cycle, so the active slice always sits in the low bits;
  // bit SLICE of the widened difference is the borrow out of the slice.
  assign w_sub       = {1'b0, r_a[SLICE-1:0]} - {1'b0, r_b[SLICE-1:0]} - (SLICE+1)'(r_borrow);
  assign w_part_next = {w_sub[SLICE-1:0], r_part[WIDTH-1:SLICE]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_part   <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_of     <= 1'b0;
    end else if (w_accept) begin
      r_k      <= '0;
      r_a      <= a;
      r_b      <= b;
      r_part   <= '0;
      r_borrow <= bin;
    end else if (r_state == S_RUN) begin
      r_a      <= r_a >> SLICE;
      r_b      <= r_b >> SLICE;
      r_part   <= w_part_next;
      r_borrow <= w_sub[SLICE];
      r_k      <= r_k + KW'(1);
      // On the last slice the low bits of r_a/r_b hold the operand sign bits.
      if (w_last) begin
        r_diff <= w_part_next;
        r_bout <= w_sub[SLICE];
        r_of   <= (r_a[SLICE-1] != r_b[SLICE-1]) && (w_sub[SLICE-1] != r_a[SLICE-1]);
      end
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign diff        = r_diff;
  assign bout        = r_bout;
  assign of          = r_of;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nibble_serial_sub32.sv
// Bench for nibble_serial_sub32: table of directed vectors, random operations, and
// hand-written sequences for input churn, back-to-back starts and mid-run reset.
module tb_nibble_serial_sub32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         of;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // {diff, bout, of}
  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         o;
  } vec_t;

  vec_t vecs[8];

  nibble_serial_sub32 #(.WIDTH(W), .SLICE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .bout       (bout),
    .of         (of),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
    logic [W:0]   t;
    logic [W-1:0] d;
    logic         o;
    t = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbin);
    d = t[W-1:0];
    o = (ma[W-1] != mb[W-1]) && (d[W-1] != ma[W-1]);
    return {d, t[W], o};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_done: got done=1 expected no pending result");
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("sb_diff", 64'(diff), 64'(e[W+1:2]));
        check("sb_bout", 64'(bout), 64'(e[1]));
        check("sb_of",   64'(of),   64'(e[0]));
      end
    end
  end

  // Drives one start at the current (post-edge) time; returns latency to done and busy count.
  // Operand inputs are scrambled during the run to show they are not re-sampled.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                        output int lat, output int bcnt);
    a     = ta;
    b     = tb_;
    bin   = tbin;
    start = 1'b1;
    exp_q.push_back(model(ta, tb_, tbin));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    bin   = 1'($urandom_range(0, 1));
    lat   = 0;
    bcnt  = busy ? 1 : 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    int dcount;
    int dcycle;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;
    logic [W+1:0] m;

    vecs[0] = '{a: 32'h0000_0005, b: 32'h0000_0003, bin: 1'b0, d: 32'h0000_0002, bo: 1'b0, o: 1'b0};
    vecs[1] = '{a: 32'h0000_0000, b: 32'h0000_0000, bin: 1'b1, d: 32'hFFFF_FFFF, bo: 1'b1, o: 1'b0};
    vecs[2] = '{a: 32'h8000_0000, b: 32'h0000_0001, bin: 1'b0, d: 32'h7FFF_FFFF, bo: 1'b0, o: 1'b1};
    vecs[3] = '{a: 32'h7FFF_FFFF, b: 32'hFFFF_FFFF, bin: 1'b0, d: 32'h8000_0000, bo: 1'b1, o: 1'b1};
    vecs[4] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, bin: 1'b1, d: 32'hFFFF_FFFF, bo: 1'b1, o: 1'b0};
    vecs[5] = '{a: 32'h1234_5678, b: 32'h1234_5678, bin: 1'b0, d: 32'h0000_0000, bo: 1'b0, o: 1'b0};
    vecs[6] = '{a: 32'h0000_0010, b: 32'h0000_000F, bin: 1'b1, d: 32'h0000_0000, bo: 1'b0, o: 1'b0};
    vecs[7] = '{a: 32'h0000_0100, b: 32'h0000_0001, bin: 1'b0, d: 32'h0000_00FF, bo: 1'b0, o: 1'b0};

    // Reset state
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_done",  64'(done),      64'd0);
    check("rst_diff",  64'(diff),      64'd0);
    check("rst_bout",  64'(bout),      64'd0);
    check("rst_of",    64'(of),        64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, bcnt);
      check("vec_latency", 64'(lat),  64'd8);
      check("vec_busy",    64'(bcnt), 64'd8);
      check("vec_diff",    64'(diff), 64'(vecs[i].d));
      check("vec_bout",    64'(bout), 64'(vecs[i].bo));
      check("vec_of",      64'(of),   64'(vecs[i].o));
      @(posedge clk);
      #1;
      check("vec_done_single", 64'(done),      64'd0);
      check("vec_idle_state",  64'(dbg_state), 64'd0);
      check("vec_diff_hold",   64'(diff),      64'(vecs[i].d));
    end

    // Random operations
    for (int i = 0; i < 6; i++) begin
      ra   = $urandom;
      rb   = (i == 0) ? ra : $urandom;
      rbin = 1'($urandom_range(0, 1));
      m    = model(ra, rb, rbin);
      run_op(ra, rb, rbin, lat, bcnt);
      check("rnd_latency", 64'(lat),  64'd8);
      check("rnd_diff",    64'(diff), 64'(m[W+1:2]));
      @(posedge clk);
      #1;
    end

    // Input churn during RUN with a stray start at cycle 3
    a = 32'h10; b = 32'h0F; bin = 1'b1; start = 1'b1;
    exp_q.push_back(model(32'h10, 32'h0F, 1'b1));
    @(posedge clk);
    #1;
    dcount = 0;
    dcycle = 0;
    for (int n = 1; n <= 12; n++) begin
      a     = $urandom;
      b     = $urandom;
      bin   = 1'($urandom_range(0, 1));
      start = (n == 3);
      @(posedge clk);
      #1;
      if (done) begin
        dcount++;
        dcycle = n;
        check("churn_diff", 64'(diff), 64'd0);
        check("churn_bout", 64'(bout), 64'd0);
        check("churn_of",   64'(of),   64'd0);
      end
    end
    start = 1'b0;
    check("churn_done_count", 64'(dcount), 64'd1);
    check("churn_done_cycle", 64'(dcycle), 64'd8);

    // Back-to-back: second start issued during the DONE cycle
    run_op(32'd5, 32'd3, 1'b0, lat, bcnt);
    check("b2b_first_latency", 64'(lat), 64'd8);
    run_op(32'd9, 32'd4, 1'b0, lat, bcnt);
    check("b2b_done_gap", 64'(lat + 1), 64'd9);
    check("b2b_diff",     64'(diff),    64'd5);
    @(posedge clk);
    #1;

    // Reset mid-operation
    a = 32'd5; b = 32'd3; bin = 1'b0; start = 1'b1;
    exp_q.push_back(model(32'd5, 32'd3, 1'b0));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("abort_busy",  64'(busy),      64'd0);
    check("abort_done",  64'(done),      64'd0);
    check("abort_diff",  64'(diff),      64'd0);
    check("abort_bout",  64'(bout),      64'd0);
    check("abort_of",    64'(of),        64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    dcount = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("abort_no_done",   64'(dcount), 64'd0);
    check("abort_diff_hold", 64'(diff),   64'd0);

    // Start on the first edge after reset release
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(32'hDEAD_BEEF, 32'h0000_BEEF, 1'b0, lat, bcnt);
    check("post_rst_latency", 64'(lat),  64'd8);
    check("post_rst_diff",    64'(diff), 64'hDEAD_0000);

    repeat (3) @(posedge clk);
    #1;
    check("sb_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
